dram_req_sched: RTL and testbench
=================================

DRAM_REQ_SCHED -- requirements
Module: dram_req_sched

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, request slots; MAX_BYPASS, 3, maximum times the oldest entry may be overtaken; TIMEOUT, 16, bank wait limit in cycles.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous, active-high.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_row  in  4  requested row number.
REQ-007 req_tag  in  2  requester tag, returned with the response.
REQ-008 req_ready  out  1  slot free; a transfer occurs when req_valid and req_ready are both high at an edge.
REQ-009 bank_row  out  4  row driven to the dram_bank row_num input.
REQ-010 bank_valid  out  1  drives the dram_bank input_valid input.
REQ-011 bank_data  in  32  dram_bank output_data.
REQ-012 bank_data_valid  in  1  dram_bank output_valid.
REQ-013 resp_valid, resp_tag[1:0], resp_row[3:0], resp_data[31:0], resp_err  out  response pulse, tag, row, data, and timeout flag.

Function
REQ-014 Request storage SHALL be a DEPTH-entry buffer with age order; req_ready SHALL be high iff fewer than DEPTH entries are held, including in the cycle an entry is being issued.
REQ-015 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-016 In IDLE with at least one entry, the FSM SHALL select an entry, remove it from the buffer, register bank_row and set bank_valid=1 at the next edge, and enter BUSY.
REQ-017 Selection SHALL pick the oldest entry whose row equals open_row when open_row_valid=1; otherwise it SHALL pick the oldest entry.
REQ-018 When a hit overtakes the oldest entry, bypass_cnt SHALL increment; when bypass_cnt equals MAX_BYPASS, the oldest entry SHALL be selected unconditionally; bypass_cnt SHALL clear whenever the oldest entry is issued.
REQ-019 In BUSY, bank_valid SHALL stay high and bank_row SHALL stay stable until bank_data_valid=1; bank_data_valid SHALL be honoured from the first BUSY cycle, which covers a zero-latency hit.
REQ-020 On the BUSY edge with bank_data_valid=1, the block SHALL capture bank_data, the issued tag and the issued row, set open_row to the issued row and open_row_valid=1, drop bank_valid, and enter RESP.
REQ-021 In RESP, resp_valid SHALL be high for exactly one cycle (there is no response backpressure), and the next state SHALL be IDLE.
REQ-022 Timeout: if BUSY lasts TIMEOUT cycles without bank_data_valid, the block SHALL enter RESP with resp_err=1 and resp_data=0, drop bank_valid, and clear open_row_valid.
REQ-023 bank_data_valid outside BUSY SHALL be ignored.
REQ-024 An enqueue in the same cycle as a removal SHALL be accepted, and the new entry SHALL be the youngest.
REQ-025 An entry enqueued at edge E into an empty buffer while the FSM is in IDLE SHALL drive bank_valid high after edge E+1.
REQ-026 resp_* outputs SHALL hold their last values when resp_valid=0.

Reset
REQ-027 On rst=1 at an edge, the block SHALL clear the buffer and bypass_cnt, set open_row_valid=0, set the state to IDLE, and force req_ready=1 and every other output to 0.
REQ-028 Reset during BUSY or RESP SHALL discard the outstanding request, and a bank_data_valid arriving after reset SHALL produce no response.

Structure
REQ-029 Package dram_ctrl_pkg SHALL hold ROW_W=4, DATA_W=32 and TAG_W=2, the state enum, and the request-entry struct {row, tag}.
REQ-030 A single sub-module, dram_hit_picker, SHALL be combinational and map (entry rows, valid bits, age order, open_row, open_row_valid, force_oldest) to the selected index.

Verification
REQ-031 Directed scenario: after reset, enqueue row 0, tag 0; bank_data_valid is then asserted with bank_data=5 two cycles after bank_valid rises -> bank_row=0, then resp_valid for 1 cycle with tag 0, data 5, err 0.
REQ-032 Directed scenario: with open_row=8, enqueue row 15 tag 1 then row 8 tag 2 while BUSY -> row 8 issued first; responses ordered tag 2 then tag 1.
REQ-033 Directed scenario: with open_row=0, the oldest entry is row 10, followed by a steady stream of row-0 requests -> exactly 3 row-0 issues, then row 10 issued.
REQ-034 Directed scenario: bank stalled, 5 requests offered -> 4 accepted and req_ready=0; the 5th is accepted on the edge the FSM moves IDLE->BUSY.
REQ-035 Directed scenario: bank_data_valid never asserted -> resp_valid after 16 BUSY cycles with resp_err=1, data 0, and the next request is treated as a miss.
REQ-036 Directed scenario: rst pulsed mid-BUSY, then bank_data_valid=1 -> bank_valid=0, req_ready=1, and no resp_valid.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared widths, scheduler state encoding and request-entry layout for the
// DRAM request scheduler.
package dram_ctrl_pkg;

    localparam int unsigned ROW_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [TAG_W-1:0] tag;
    } req_entry_t;

endpackage

// File: rtl/dram_hit_picker.sv
// Combinational entry selector: oldest open-row hit when allowed, otherwise
// the oldest entry. Age order is the slot index (slot 0 is the oldest).
module dram_hit_picker
    import dram_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0][ROW_W-1:0] entry_rows,
    input  logic [DEPTH-1:0]            entry_valid,
    input  logic [ROW_W-1:0]            open_row,
    input  logic                        open_row_valid,
    input  logic                        force_oldest,
    output logic [IDX_W-1:0]            sel_idx
);

    logic [IDX_W-1:0] oldest_idx;
    logic [IDX_W-1:0] hit_idx;
    logic             found_oldest;
    logic             found_hit;

    // Scan in age order for the oldest valid entry and the oldest row hit.
    always_comb begin
        oldest_idx   = '0;
        hit_idx      = '0;
        found_oldest = 1'b0;
        found_hit    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !found_oldest) begin
                oldest_idx   = IDX_W'(i);
                found_oldest = 1'b1;
            end
            if (entry_valid[i] && (entry_rows[i] == open_row) && !found_hit) begin
                hit_idx   = IDX_W'(i);
                found_hit = 1'b1;
            end
        end
        sel_idx = (open_row_valid && found_hit && !force_oldest) ? hit_idx : oldest_idx;
    end

endmodule

// File: rtl/dram_req_sched.sv
// DRAM request scheduler: buffers requests in age order, issues one at a
// time to a single bank favouring open-row hits with a bypass limit, and
// returns tagged responses with a bank-wait timeout.
module dram_req_sched
    import dram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_BYPASS = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_ready,
    output logic [ROW_W-1:0]  bank_row,
    output logic              bank_valid,
    input  logic [DATA_W-1:0] bank_data,
    input  logic              bank_data_valid,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [ROW_W-1:0]  resp_row,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned BYP_W = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [BYP_W-1:0] BYP_MAX_C  = BYP_W'(MAX_BYPASS);
    localparam logic [TMR_W-1:0] TMR_LAST_C = TMR_W'(TIMEOUT - 1);

    state_t                       state, state_n;
    req_entry_t [DEPTH-1:0]       entries, entries_n;
    logic [CNT_W-1:0]             count, count_n;
    logic [BYP_W-1:0]             bypass_cnt;
    logic [TMR_W-1:0]             timer;
    logic [ROW_W-1:0]             open_row;
    logic                         open_row_valid;
    logic [TAG_W-1:0]             cur_tag;
    logic [DEPTH-1:0][ROW_W-1:0]  slot_rows;
    logic [DEPTH-1:0]             slot_valid;
    logic [IDX_W-1:0]             sel_idx;
    logic                         issue;
    logic                         push;
    logic                         timeout_hit;

    // The issuing slot frees up on the same edge, so it does not block a push.
    assign issue       = (state == IDLE) && (count != '0);
    assign req_ready   = (count < DEPTH_C) || issue;
    assign push        = req_valid && req_ready;
    assign timeout_hit = (timer == TMR_LAST_C);
    assign resp_valid  = (state == RESP);

    // Present slot rows and occupancy to the picker.
    always_comb begin
        slot_rows  = '0;
        slot_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_rows[i]  = entries[i].row;
            slot_valid[i] = (i < 32'(count));
        end
    end

    dram_hit_picker #(
        .DEPTH (DEPTH)
    ) u_picker (
        .entry_rows     (slot_rows),
        .entry_valid    (slot_valid),
        .open_row       (open_row),
        .open_row_valid (open_row_valid),
        .force_oldest   (bypass_cnt == BYP_MAX_C),
        .sel_idx        (sel_idx)
    );

    // Remove the issued slot by shifting younger slots down, then append any push.
    always_comb begin
        entries_n = entries;
        count_n   = count;
        if (issue) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (i >= 32'(sel_idx)) begin
                    entries_n[IDX_W'(i)] = entries[IDX_W'(i + 1)];
                end
            end
            count_n = count - CNT_W'(1);
        end
        if (push) begin
            entries_n[IDX_W'(count_n)] = '{row: req_row, tag: req_tag};
            count_n = count_n + CNT_W'(1);
        end
    end

    // Next-state logic for the issue/wait/respond sequence.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (count != '0) state_n = BUSY;
            BUSY:    if (bank_data_valid || timeout_hit) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Buffer, issue, open-row tracking and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries        <= '0;
            count          <= '0;
            bypass_cnt     <= '0;
            timer          <= '0;
            open_row       <= '0;
            open_row_valid <= 1'b0;
            cur_tag        <= '0;
            bank_row       <= '0;
            bank_valid     <= 1'b0;
            resp_tag       <= '0;
            resp_row       <= '0;
            resp_data      <= '0;
            resp_err       <= 1'b0;
        end else begin
            entries <= entries_n;
            count   <= count_n;
            case (state)
                IDLE: begin
                    if (issue) begin
                        bank_row   <= entries[sel_idx].row;
                        cur_tag    <= entries[sel_idx].tag;
                        bank_valid <= 1'b1;
                        timer      <= '0;
                        bypass_cnt <= (sel_idx == '0) ? '0 : bypass_cnt + BYP_W'(1);
                    end
                end
                BUSY: begin
                    if (bank_data_valid) begin
                        resp_data      <= bank_data;
                        resp_tag       <= cur_tag;
                        resp_row       <= bank_row;
                        resp_err       <= 1'b0;
                        open_row       <= bank_row;
                        open_row_valid <= 1'b1;
                        bank_valid     <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data      <= '0;
                        resp_tag       <= cur_tag;
                        resp_row       <= bank_row;
                        resp_err       <= 1'b1;
                        open_row_valid <= 1'b0;
                        bank_valid     <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_sched.sv
// Self-checking bench for dram_req_sched: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dram_req_sched;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] row;
        logic [1:0] tag;
    } mentry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_row = '0;
    logic [1:0]  req_tag = '0;
    logic        req_ready;
    logic [3:0]  bank_row;
    logic        bank_valid;
    logic [31:0] bank_data = '0;
    logic        bank_data_valid = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_tag;
    logic [3:0]  resp_row;
    logic [31:0] resp_data;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_req_sched #(
        .DEPTH      (4),
        .MAX_BYPASS (3),
        .TIMEOUT    (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_row         (req_row),
        .req_tag         (req_tag),
        .req_ready       (req_ready),
        .bank_row        (bank_row),
        .bank_valid      (bank_valid),
        .bank_data       (bank_data),
        .bank_data_valid (bank_data_valid),
        .resp_valid      (resp_valid),
        .resp_tag        (resp_tag),
        .resp_row        (resp_row),
        .resp_data       (resp_data),
        .resp_err        (resp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        bank_data_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] r, input logic [1:0] t);
        req_valid = 1'b1;
        req_row = r;
        req_tag = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_issue(output logic [3:0] row, output bit ok);
        int n = 0;
        while (bank_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (bank_valid === 1'b1);
        row = bank_row;
    endtask

    task automatic answer(input logic [31:0] d, output logic [1:0] tag,
                          output logic [31:0] data, output logic err, output bit ok);
        bank_data = d;
        bank_data_valid = 1'b1;
        tick();
        bank_data_valid = 1'b0;
        ok = (resp_valid === 1'b1);
        tag = resp_tag;
        data = resp_data;
        err = resp_err;
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        req_row = 4'h9;
        bank_data_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        bank_data_valid = 1'b0;
        checks++;
        if ({req_ready, bank_valid, resp_valid, resp_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, bank_valid, resp_valid, resp_err});
        end
        checks++;
        if ({bank_row, resp_tag, resp_row} !== 10'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", {bank_row, resp_tag, resp_row});
        end
        checks++;
        if (resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", resp_data);
        end
    endtask

    task automatic test_basic();
        logic [1:0] t; logic [31:0] d; logic e; bit ok;
        do_reset();
        push(4'd0, 2'd0);
        checks++;
        if (bank_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_early_issue: bank_valid got %b expected 0", bank_valid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bank_valid, bank_row} !== 5'h10) begin
                errors++;
                $display("FAIL basic_issue[%0d]: got %h expected 10", i, {bank_valid, bank_row});
            end
            if (i < 2) tick();
        end
        answer(32'd5, t, d, e, ok);
        checks++;
        if ({ok, t, e, resp_row, bank_valid} !== 9'b1_00_0_0000_0) begin
            errors++;
            $display("FAIL basic_resp: got %b expected 100000000", {ok, t, e, resp_row, bank_valid});
        end
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL basic_data: got %0d expected 5", d);
        end
        tick();
        checks++;
        if ({resp_valid, resp_data} !== {1'b0, 32'd5}) begin
            errors++;
            $display("FAIL basic_pulse_hold: got %b/%0d expected 0/5", resp_valid, resp_data);
        end
    endtask

    task automatic test_hit_first();
        logic [3:0] r; logic [1:0] t; logic [31:0] d; logic e; bit ok, ok2;
        do_reset();
        push(4'd8, 2'd3);
        push(4'd15, 2'd1);
        push(4'd8, 2'd2);
        answer(32'h33, t, d, e, ok);
        checks++;
        if ({ok, t} !== 3'b111) begin
            errors++;
            $display("FAIL hit_first_resp: got %b expected 111", {ok, t});
        end
        wait_issue(r, ok);
        answer(32'h44, t, d, e, ok2);
        checks++;
        if ({ok, ok2, r, t} !== {2'b11, 4'd8, 2'd2}) begin
            errors++;
            $display("FAIL hit_first_pick: got row %0d tag %0d expected row 8 tag 2", r, t);
        end
        wait_issue(r, ok);
        answer(32'h55, t, d, e, ok2);
        checks++;
        if ({ok, ok2, r, t} !== {2'b11, 4'd15, 2'd1}) begin
            errors++;
            $display("FAIL hit_second_pick: got row %0d tag %0d expected row 15 tag 1", r, t);
        end
    endtask

    task automatic test_bypass_limit();
        logic [3:0] r; logic [1:0] t; logic [31:0] d; logic e; bit ok, ok2;
        do_reset();
        push(4'd0, 2'd0);
        wait_issue(r, ok);
        push(4'd10, 2'd1);
        push(4'd0, 2'd2);
        answer(32'h1, t, d, e, ok2);
        for (int k = 0; k < 4; k++) begin
            wait_issue(r, ok);
            push(4'd0, 2'(k));
            answer(32'(k), t, d, e, ok2);
            checks++;
            if ({ok, ok2, r} !== {2'b11, (k < 3) ? 4'd0 : 4'd10}) begin
                errors++;
                $display("FAIL bypass_order[%0d]: got row %0d ok %b%b expected row %0d",
                         k, r, ok, ok2, (k < 3) ? 0 : 10);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int c;
        logic rdy;
        do_reset();
        push(4'd1, 2'd0);
        for (c = 0; c < 10 && n_acc < 4; c++) begin
            req_valid = 1'b1;
            req_row = 4'(2 + n_acc);
            req_tag = 2'(n_acc);
            rdy = req_ready;
            tick();
            if (rdy) n_acc++;
        end
        req_row = 4'd6;
        checks++;
        if ({n_acc == 4, req_ready, bank_valid} !== 3'b101) begin
            errors++;
            $display("FAIL backpressure_full: accepted %0d ready %b bank_valid %b expected 4/0/1",
                     n_acc, req_ready, bank_valid);
        end
        c = 0;
        while (req_ready !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        checks++;
        if ({req_ready, bank_valid} !== 2'b10) begin
            errors++;
            $display("FAIL backpressure_reopen: ready %b bank_valid %b expected 1/0", req_ready, bank_valid);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({req_ready, bank_valid} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_fifth: ready %b bank_valid %b expected 0/1", req_ready, bank_valid);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] r; logic [1:0] t; logic [31:0] d; logic e; bit ok, ok2;
        int n;
        do_reset();
        push(4'd5, 2'd0);
        wait_issue(r, ok);
        answer(32'hAB, t, d, e, ok2);
        push(4'd7, 2'd1);
        wait_issue(r, ok);
        checks++;
        if ({ok, r} !== {1'b1, 4'd7}) begin
            errors++;
            $display("FAIL timeout_issue: got row %0d ok %b expected row 7", r, ok);
        end
        n = 0;
        push(4'd3, 2'd2); n++;
        push(4'd5, 2'd3); n++;
        while (resp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected 16", n);
        end
        checks++;
        if ({resp_valid, resp_err, resp_tag, bank_valid, resp_data} !== {1'b1, 1'b1, 2'd1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resp: valid %b err %b tag %0d bank_valid %b data %h expected 1/1/1/0/0",
                     resp_valid, resp_err, resp_tag, bank_valid, resp_data);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: resp_valid got %b expected 0", resp_valid);
        end
        wait_issue(r, ok);
        checks++;
        if ({ok, r} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL timeout_miss: got row %0d expected 3", r);
        end
        answer(32'h1, t, d, e, ok2);
        wait_issue(r, ok);
        answer(32'h2, t, d, e, ok2);
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] r; bit ok;
        do_reset();
        push(4'd4, 2'd1);
        wait_issue(r, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ok, bank_valid, req_ready, resp_valid} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_busy_state: got %b expected 1010", {ok, bank_valid, req_ready, resp_valid});
        end
        bank_data = 32'd77;
        bank_data_valid = 1'b1;
        tick();
        bank_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({resp_valid, bank_valid, resp_data} !== 34'h0) begin
                errors++;
                $display("FAIL rst_busy_noresp[%0d]: valid %b bank_valid %b data %h expected 0/0/0",
                         i, resp_valid, bank_valid, resp_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        mentry_t     q[$];
        mentry_t     cur;
        bit          free, outst, resp_pend, exp_issue, acc, bdv_now, val_now, room;
        int          busy_n, lat, byp, pick;
        logic [3:0]  mopen, row_now;
        bit          mov;
        logic [1:0]  tag_now, e_tag;
        logic [3:0]  e_row;
        logic [31:0] e_data, data_now;
        logic        e_err;
        do_reset();
        free = 1; outst = 0; resp_pend = 0; busy_n = 0; lat = 0; byp = 0;
        mov = 0; mopen = '0; cur = '0;
        e_tag = '0; e_row = '0; e_data = '0; e_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            val_now  = ($urandom_range(0, 2) != 0);
            row_now  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 2));
            tag_now  = 2'($urandom);
            data_now = $urandom;
            bdv_now  = outst ? (busy_n == lat) : ($urandom_range(0, 3) == 0);
            req_valid = val_now;
            req_row = row_now;
            req_tag = tag_now;
            bank_data = data_now;
            bank_data_valid = bdv_now;
            exp_issue = free && (q.size() > 0);
            room = (q.size() < DEPTH) || exp_issue;
            checks++;
            if (req_ready !== room) begin
                errors++;
                $display("FAIL rand_ready@%0d: got %b expected %b", cyc, req_ready, room);
            end
            acc = val_now && room;
            tick();
            if (resp_pend) begin
                resp_pend = 0;
                free = 1;
            end else if (outst) begin
                if (bdv_now) begin
                    e_data = data_now; e_err = 1'b0; e_tag = cur.tag; e_row = cur.row;
                    mopen = cur.row; mov = 1;
                    resp_pend = 1; outst = 0;
                end else if (busy_n == 15) begin
                    e_data = '0; e_err = 1'b1; e_tag = cur.tag; e_row = cur.row;
                    mov = 0;
                    resp_pend = 1; outst = 0;
                end else begin
                    busy_n++;
                end
            end else if (exp_issue) begin
                pick = 0;
                if (byp < 3 && mov) begin
                    for (int k = 0; k < q.size(); k++) begin
                        if (q[k].row == mopen) begin
                            pick = k;
                            break;
                        end
                    end
                end
                byp = (pick != 0) ? byp + 1 : 0;
                cur = q[pick];
                q.delete(pick);
                free = 0; outst = 1; busy_n = 0;
                lat = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 3);
                checks++;
                if (bank_row !== cur.row) begin
                    errors++;
                    $display("FAIL rand_issue_row@%0d: got %0d expected %0d", cyc, bank_row, cur.row);
                end
            end
            if (acc) q.push_back('{row: row_now, tag: tag_now});
            checks++;
            if ({bank_valid, resp_valid} !== {outst, resp_pend}) begin
                errors++;
                $display("FAIL rand_valids@%0d: got %b%b expected %b%b", cyc, bank_valid, resp_valid, outst, resp_pend);
            end
            checks++;
            if ({resp_tag, resp_row, resp_data, resp_err} !== {e_tag, e_row, e_data, e_err}) begin
                errors++;
                $display("FAIL rand_resp@%0d: got tag %0d row %0d data %h err %b expected tag %0d row %0d data %h err %b",
                         cyc, resp_tag, resp_row, resp_data, resp_err, e_tag, e_row, e_data, e_err);
            end
        end
        req_valid = 1'b0;
        bank_data_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_hit_first();
        test_bypass_limit();
        test_backpressure();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
